// File: rtl/door_controller.sv
// ---------------------------------------------------------------------------
// door_controller
//
// Door sequencer for the elevator car. It walks the door through
// CLOSED -> OPENING -> OPEN -> CLOSING. While the car is overloaded it holds
// the door open and sounds the alarm. Once the operator or sensor confirms
// that the excess load has left, it sends a one-cycle clear pulse to the
// weight stage. The car may move only while the door is fully closed.
//
// Parameters
//   TRANSIT_TIME : cycles for the door to fully open or fully close (>= 1)
//   OPEN_TIME    : dwell cycles at fully open before auto-close (>= 1)
//
// Ports
//   clk                   in  : system clock, rising edge
//   reset                 in  : asynchronous, active-high reset
//   arrived               in  : car stopped at a requested floor
//   open_request          in  : open-door button
//   close_request         in  : close-door button
//   weight_limit_exceeded in  : overload flag from the weight stage
//   clear_overload        in  : confirmation that the excess load has left
//   door                  out : 1 whenever the door is not fully closed
//   motion_enable         out : 1 only when the door is closed and sealed
//   alarm                 out : overload buzzer
//   weight_flip_reset     out : clear pulse to the weight stage
// ---------------------------------------------------------------------------
module door_controller #(
    parameter int TRANSIT_TIME = 4,
    parameter int OPEN_TIME    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic arrived,
    input  logic open_request,
    input  logic close_request,
    input  logic weight_limit_exceeded,
    input  logic clear_overload,
    output logic door,
    output logic motion_enable,
    output logic alarm,
    output logic weight_flip_reset
);

    // The timer is wide enough to hold the larger of the two load values.
    localparam int MAX_TIME = (TRANSIT_TIME > OPEN_TIME) ? TRANSIT_TIME : OPEN_TIME;
    localparam int TIMER_W  = (MAX_TIME > 1) ? $clog2(MAX_TIME) : 1;

    localparam logic [TIMER_W-1:0] TRANSIT_LOAD = TIMER_W'(TRANSIT_TIME - 1);
    localparam logic [TIMER_W-1:0] DWELL_LOAD   = TIMER_W'(OPEN_TIME - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

    typedef enum logic [2:0] {
        ST_CLOSED   = 3'd0,
        ST_OPENING  = 3'd1,
        ST_OPEN     = 3'd2,
        ST_CLOSING  = 3'd3,
        ST_OVERLOAD = 3'd4,
        ST_CLEAR    = 3'd5
    } state_t;

    state_t               state_reg, state_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic                 timer_zero;

    logic door_reg, door_next;
    logic motion_enable_reg, motion_enable_next;
    logic alarm_reg, alarm_next;
    logic weight_flip_reset_reg, weight_flip_reset_next;

    assign timer_zero = (timer_reg == '0);

    // -----------------------------------------------------------------------
    // Next-state and timer logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;

        case (state_reg)
            ST_CLOSED: begin
                // An overload flag does not block opening here. It is
                // caught on the first OPEN cycle instead.
                if (arrived || open_request) begin
                    state_next = ST_OPENING;
                    timer_next = TRANSIT_LOAD;
                end
            end

            ST_OPENING: begin
                if (timer_zero) begin
                    state_next = ST_OPEN;
                    timer_next = DWELL_LOAD;
                end else begin
                    timer_next = timer_reg - TIMER_ONE;
                end
            end

            ST_OPEN: begin
                // Priority order: overload, open (beats close), close, dwell expiry.
                if (weight_limit_exceeded) begin
                    state_next = ST_OVERLOAD;
                end else if (open_request) begin
                    timer_next = DWELL_LOAD;
                end else if (close_request || timer_zero) begin
                    state_next = ST_CLOSING;
                    timer_next = TRANSIT_LOAD;
                end else begin
                    timer_next = timer_reg - TIMER_ONE;
                end
            end

            ST_CLOSING: begin
                // A reopen always runs the full transit, whatever the
                // current door position is.
                if (weight_limit_exceeded || open_request) begin
                    state_next = ST_OPENING;
                    timer_next = TRANSIT_LOAD;
                end else if (timer_zero) begin
                    state_next = ST_CLOSED;
                end else begin
                    timer_next = timer_reg - TIMER_ONE;
                end
            end

            ST_OVERLOAD: begin
                // The timer stays frozen and the door buttons are ignored.
                if (clear_overload) begin
                    state_next = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                // Single cycle. The overload flag is still falling, so it
                // is not looked at here.
                state_next = ST_OPEN;
                timer_next = DWELL_LOAD;
            end

            default: begin
                state_next = ST_CLOSED;
                timer_next = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode from the next state. The outputs are registered, so
    // weight_flip_reset is glitch-free. It drives an asynchronous reset
    // downstream.
    // -----------------------------------------------------------------------
    always_comb begin
        door_next              = (state_next != ST_CLOSED);
        motion_enable_next     = (state_next == ST_CLOSED);
        alarm_next             = (state_next == ST_OVERLOAD);
        weight_flip_reset_next = (state_next == ST_CLEAR);
    end

    // weight_flip_reset resets to 1, so the weight stage is held clear while
    // reset is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg             <= ST_CLOSED;
            timer_reg             <= '0;
            door_reg              <= 1'b0;
            motion_enable_reg     <= 1'b1;
            alarm_reg             <= 1'b0;
            weight_flip_reset_reg <= 1'b1;
        end else begin
            state_reg             <= state_next;
            timer_reg             <= timer_next;
            door_reg              <= door_next;
            motion_enable_reg     <= motion_enable_next;
            alarm_reg             <= alarm_next;
            weight_flip_reset_reg <= weight_flip_reset_next;
        end
    end

    assign door              = door_reg;
    assign motion_enable     = motion_enable_reg;
    assign alarm             = alarm_reg;
    assign weight_flip_reset = weight_flip_reset_reg;

endmodule
